in_sync_buf: RTL and testbench
==============================

IN_SYNC_BUF -- requirements
Module: in_sync_buf

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_LINES, default 16: FIFO depth in words, power of 2, minimum 4.
REQ-002 The block SHALL have parameter PIX_WIDTH, default 42: one pixel, 3 components x 14 bits.
REQ-003 The block SHALL have parameter PIX_PER_WORD, default 4: pixels packed into one FIFO word; DATA_WIDTH = PIX_PER_WORD*PIX_WIDTH.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low, applies to both clock domains.
REQ-005 The block SHALL have port clk_wr  input  1  pixel-input (write) clock.
REQ-006 The block SHALL have port clk_rd  input  1  encoder core (read) clock.
REQ-007 The block SHALL have port in_pix  input  PIX_WIDTH  pixel, clk_wr domain.
REQ-008 The block SHALL have port in_valid  input  1  in_pix qualifier.
REQ-009 The block SHALL have port in_sof  input  1  first pixel of slice, qualified by in_valid.
REQ-010 The block SHALL have port in_eol  input  1  last pixel of line, qualified by in_valid.
REQ-011 The block SHALL have port in_ready  output  1  clk_wr domain; source shall stop after at most 2 more pixels when low.
REQ-012 The block SHALL have port overflow  output  1  sticky word-drop flag, clk_wr domain.
REQ-013 The block SHALL have port out_data  output  DATA_WIDTH  packed word, pixel 0 in LSBs, clk_rd domain.
REQ-014 The block SHALL have port out_valid  output  1  out_data/out_sof/out_eol valid.
REQ-015 The block SHALL have port out_ready  input  1  consumer accept; transfer = out_valid & out_ready.
REQ-016 The block SHALL have port out_sof  output  1  word contains the slice's first pixel.
REQ-017 The block SHALL have port out_eol  output  1  word contains a line's last pixel.

Function
REQ-018 The packer SHALL place accepted pixels into slots 0..PIX_PER_WORD-1 in arrival order, using a slot counter.
REQ-019 A word SHALL be committed when slot PIX_PER_WORD-1 is filled or when in_eol is accepted.
REQ-020 On an in_eol partial word, unfilled slots SHALL replicate the last pixel, and the slot counter SHALL return to 0.
REQ-021 in_sof with a partial word pending SHALL discard that word; the sof pixel SHALL go into slot 0 with the word's sof tag set.
REQ-022 Each committed word SHALL be stored in RAM together with its sof and eol tags, DATA_WIDTH+2 bits per line.
REQ-023 The RAM write SHALL occur on the clk_wr edge after the completing pixel is sampled, and the write pointer SHALL advance on that same edge.
REQ-024 Pointers SHALL be ADDR_WIDTH = log2(NUMBER_OF_LINES)+1 bits, binary internally and Gray-coded for crossing.
REQ-025 Each Gray pointer SHALL cross to the other domain through 2-flop synchronizers.
REQ-026 Full (clk_wr) SHALL be true when the write Gray pointer equals the synced read Gray pointer with its 2 MSBs inverted.
REQ-027 Empty (clk_rd) SHALL be true when the synced write pointer equals the read pointer.
REQ-028 in_ready SHALL be registered and low whenever write-domain fullness >= NUMBER_OF_LINES-2.
REQ-029 A commit while full SHALL drop the word, leave the pointer unchanged, and set overflow on the next edge.
REQ-030 overflow SHALL clear only on accepted in_sof or on reset; if a drop coincides with in_sof, set SHALL win.
REQ-031 The read side SHALL be first-word-fall-through with a registered output stage: out_valid rises when not empty, and out_data, out_sof and out_eol shall stay stable while out_valid & ~out_ready.
REQ-032 On a transfer, the next word SHALL be presented the following clk_rd cycle if available, sustaining 1 word/cycle.
REQ-033 A committed word SHALL reach out_valid within 4 clk_rd cycles plus 1 clk_wr cycle.
REQ-034 Simultaneous write and read at full or empty SHALL be resolved by each domain's own view only, with no data corruption.

Reset
REQ-035 While rst_n is low, pointers, slot counter, synchronizers and output stage SHALL be 0.
REQ-036 During reset, in_ready=0, overflow=0, out_valid=0, out_sof=0 and out_eol=0.
REQ-037 out_data SHALL be 0 after reset.
REQ-038 in_ready SHALL rise on the first clk_wr edge after rst_n deasserts.
REQ-039 Reset asserted mid-frame SHALL empty the FIFO, and the first transfer after reset SHALL only be for data written after reset.

Structure
REQ-040 PIX_WIDTH, PIX_PER_WORD and tag bit positions SHALL reside in the shared encoder package.
REQ-041 The bin2gray/gray2bin functions SHALL reside in the shared encoder package.
REQ-042 A sub-module ptr_sync SHALL hold the Gray encode, per-bit synchronizer instances and gray2bin, instantiated once per direction.
REQ-043 The existing sync_dp_ram SHALL be reused for storage.

Verification
REQ-044 8 pixels 1..8, in_sof on pixel 1, out_ready=1 -> 2 words {4,3,2,1} sof=1 and {8,7,6,5} sof=0, no overflow.
REQ-045 6 pixels with in_eol on pixel 6 -> second word {6,6,6,5}, eol=1.
REQ-046 3 pixels then in_sof pixel 9 plus 3 pixels -> first word out is {12,11,10,9} sof=1; pixels 1..3 never appear.
REQ-047 out_ready=0, 80 pixels, in_ready ignored (depth 16) -> in_ready low at fullness 14, overflow=1, exactly 16 words read in order.
REQ-048 clk_wr 148.5 MHz, clk_rd 100/200 MHz random out_ready, 10k words -> in-order, lossless output when in_ready is obeyed.
REQ-049 rst_n pulsed with 5 words queued -> out_valid=0 within reset; after reset, a single new word is output alone.

Source files
------------

// File: rtl/in_sync_buf_pkg.sv
// Shared encoder package: pixel geometry, RAM tag bit offsets and Gray-code helpers.
`timescale 1ns/1ps
package in_sync_buf_pkg;

    localparam int DEF_PIX_WIDTH    = 42;
    localparam int DEF_PIX_PER_WORD = 4;

    // Tags sit directly above the packed data word in each RAM line.
    localparam int TAG_SOF_OFS = 0;
    localparam int TAG_EOL_OFS = 1;
    localparam int TAG_BITS    = 2;

    localparam int PTR_MAX_W = 16;
    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ {1'b0, bin[PTR_MAX_W-1:1]};
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Carries one FIFO pointer across clock domains: Gray-encode in the source domain,
// two-flop synchronise each bit in the destination domain, then decode back to binary.
`timescale 1ns/1ps
module ptr_sync
    import in_sync_buf_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         rst_n,
    input  logic         src_clk,
    input  logic [W-1:0] src_bin,
    input  logic         dst_clk,
    output logic [W-1:0] dst_bin
);

    logic [W-1:0] src_gray_r;
    logic [W-1:0] dst_gray_s;

    // Registered Gray copy so only one bit toggles per increment on the crossing
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            src_gray_r <= '0;
        end else begin
            src_gray_r <= W'(bin2gray(PTR_MAX_W'(src_bin)));
        end
    end

    for (genvar b = 0; b < W; b++) begin : g_bit
        logic meta_r;
        logic sync_r;

        // Two-flop synchroniser for one Gray bit
        always_ff @(posedge dst_clk or negedge rst_n) begin
            if (!rst_n) begin
                meta_r <= 1'b0;
                sync_r <= 1'b0;
            end else begin
                meta_r <= src_gray_r[b];
                sync_r <= meta_r;
            end
        end

        assign dst_gray_s[b] = sync_r;
    end

    assign dst_bin = W'(gray2bin(PTR_MAX_W'(dst_gray_s)));

endmodule

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port on independent clocks.
`timescale 1ns/1ps
module sync_dp_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          rst_n,
    input  logic          wr_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // Storage array write
    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its value while rd_en is low
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/in_sync_buf.sv
// Pixel input buffer: packs pixels into words with sof/eol tags and moves them
// from the pixel clock to the encoder clock through an asynchronous FIFO.
`timescale 1ns/1ps
module in_sync_buf
    import in_sync_buf_pkg::*;
#(
    parameter  int NUMBER_OF_LINES = 16,
    parameter  int PIX_WIDTH       = DEF_PIX_WIDTH,
    parameter  int PIX_PER_WORD    = DEF_PIX_PER_WORD,
    localparam int DATA_WIDTH      = PIX_PER_WORD * PIX_WIDTH
) (
    input  logic                  rst_n,
    input  logic                  clk_wr,
    input  logic                  clk_rd,
    input  logic [PIX_WIDTH-1:0]  in_pix,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  in_eol,
    output logic                  in_ready,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eol
);

    localparam int ADDR_WIDTH = $clog2(NUMBER_OF_LINES) + 1;
    localparam int SLOT_W     = $clog2(PIX_PER_WORD);
    localparam int ENTRY_W    = DATA_WIDTH + TAG_BITS;
    localparam logic [SLOT_W-1:0]     LAST_SLOT   = SLOT_W'(PIX_PER_WORD - 1);
    localparam logic [ADDR_WIDTH-1:0] READY_LIMIT = ADDR_WIDTH'(NUMBER_OF_LINES - 2);
    localparam logic [ADDR_WIDTH-1:0] FULL_MASK   = {2'b11, {(ADDR_WIDTH-2){1'b0}}};

    logic [SLOT_W-1:0]     slot_r, slot_base_s;
    logic [DATA_WIDTH-1:0] word_r, word_base_s, word_fill_s;
    logic                  sof_tag_r, sof_nxt_s, last_s;
    logic                  commit_r;
    logic [ENTRY_W-1:0]    entry_r, entry_s, ram_q_s;
    logic [ADDR_WIDTH-1:0] wptr_r, rbin_sync_s, wgray_s, rgray_sync_s, fullness_s;
    logic                  full_s, drop_s, wr_en_s;
    logic                  overflow_r, in_ready_r;
    logic [ADDR_WIDTH-1:0] rptr_r, rptr_nxt_s, wbin_sync_s;
    logic                  out_valid_r, xfer_s, empty_nxt_s;

    // Packer: a sof restarts the word; an eol pads the remaining slots with the last pixel
    always_comb begin
        slot_base_s = slot_r;
        word_base_s = word_r;
        sof_nxt_s   = sof_tag_r;
        if (in_sof) begin
            slot_base_s = '0;
            word_base_s = '0;
            sof_nxt_s   = 1'b1;
        end else begin
            slot_base_s = slot_r;
            word_base_s = word_r;
            sof_nxt_s   = sof_tag_r;
        end
        last_s      = (slot_base_s == LAST_SLOT) || in_eol;
        word_fill_s = word_base_s;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if ((SLOT_W'(i) == slot_base_s) || (in_eol && (SLOT_W'(i) > slot_base_s))) begin
                word_fill_s[i*PIX_WIDTH +: PIX_WIDTH] = in_pix;
            end else begin
                word_fill_s[i*PIX_WIDTH +: PIX_WIDTH] = word_base_s[i*PIX_WIDTH +: PIX_WIDTH];
            end
        end
        entry_s                           = '0;
        entry_s[DATA_WIDTH-1:0]           = word_fill_s;
        entry_s[DATA_WIDTH + TAG_SOF_OFS] = sof_nxt_s;
        entry_s[DATA_WIDTH + TAG_EOL_OFS] = in_eol;
    end

    // Packer state and the staged word awaiting its RAM write
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            slot_r    <= '0;
            word_r    <= '0;
            sof_tag_r <= 1'b0;
            commit_r  <= 1'b0;
            entry_r   <= '0;
        end else if (in_valid) begin
            if (last_s) begin
                commit_r  <= 1'b1;
                entry_r   <= entry_s;
                slot_r    <= '0;
                word_r    <= '0;
                sof_tag_r <= 1'b0;
            end else begin
                commit_r  <= 1'b0;
                slot_r    <= slot_base_s + SLOT_W'(1);
                word_r    <= word_fill_s;
                sof_tag_r <= sof_nxt_s;
            end
        end else begin
            commit_r <= 1'b0;
        end
    end

    assign wgray_s      = ADDR_WIDTH'(bin2gray(PTR_MAX_W'(wptr_r)));
    assign rgray_sync_s = ADDR_WIDTH'(bin2gray(PTR_MAX_W'(rbin_sync_s)));
    assign full_s       = (wgray_s == (rgray_sync_s ^ FULL_MASK));
    assign wr_en_s      = commit_r & ~full_s;
    assign drop_s       = commit_r & full_s;
    assign fullness_s   = wptr_r - rbin_sync_s;

    // Write pointer, sticky drop flag (set beats clear) and early back-pressure
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r     <= '0;
            overflow_r <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + ADDR_WIDTH'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (in_valid && in_sof) begin
                overflow_r <= 1'b0;
            end
            in_ready_r <= (fullness_s < READY_LIMIT);
        end
    end

    // The RAM read port is the output stage: it is addressed with the post-transfer
    // pointer so the head word is always one cycle ahead and stays put while stalled.
    assign xfer_s      = out_valid_r & out_ready;
    assign rptr_nxt_s  = rptr_r + ADDR_WIDTH'(xfer_s);
    assign empty_nxt_s = (wbin_sync_s == rptr_nxt_s);

    // Read pointer and output valid
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            rptr_r      <= rptr_nxt_s;
            out_valid_r <= ~empty_nxt_s;
        end
    end

    sync_dp_ram #(
        .DW (ENTRY_W),
        .AW (ADDR_WIDTH - 1)
    ) u_ram (
        .rst_n   (rst_n),
        .wr_clk  (clk_wr),
        .wr_en   (wr_en_s),
        .wr_addr (wptr_r[ADDR_WIDTH-2:0]),
        .wr_data (entry_r),
        .rd_clk  (clk_rd),
        .rd_en   (~empty_nxt_s),
        .rd_addr (rptr_nxt_s[ADDR_WIDTH-2:0]),
        .rd_data (ram_q_s)
    );

    ptr_sync #(.W (ADDR_WIDTH)) u_wr2rd (
        .rst_n   (rst_n),
        .src_clk (clk_wr),
        .src_bin (wptr_r),
        .dst_clk (clk_rd),
        .dst_bin (wbin_sync_s)
    );

    ptr_sync #(.W (ADDR_WIDTH)) u_rd2wr (
        .rst_n   (rst_n),
        .src_clk (clk_rd),
        .src_bin (rptr_r),
        .dst_clk (clk_wr),
        .dst_bin (rbin_sync_s)
    );

    assign in_ready  = in_ready_r;
    assign overflow  = overflow_r;
    assign out_valid = out_valid_r;
    assign out_data  = ram_q_s[DATA_WIDTH-1:0];
    assign out_sof   = ram_q_s[DATA_WIDTH + TAG_SOF_OFS];
    assign out_eol   = ram_q_s[DATA_WIDTH + TAG_EOL_OFS];

endmodule

// File: tb/tb_in_sync_buf.sv
// Directed bench for in_sync_buf: packing, sof discard, eol padding, overflow,
// mid-frame reset and a back-pressured stream with random consumer stalls.
`timescale 1ns/1ps
module tb_in_sync_buf;

    localparam int PW = 42;
    localparam int DW = 168;
    localparam int EW = 170;
    localparam int CW = 192;

    logic          rst_n, clk_wr, clk_rd;
    logic [PW-1:0] in_pix;
    logic          in_valid, in_sof, in_eol, in_ready, overflow;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, out_sof, out_eol;

    int            n_vec = 0;
    int            n_err = 0;
    int            rd_mode = 0;
    int            first_low;
    logic [EW-1:0] rxq[$];

    initial clk_wr = 1'b0;
    always #3.367 clk_wr = ~clk_wr;
    initial clk_rd = 1'b0;
    always #5 clk_rd = ~clk_rd;

    in_sync_buf dut (
        .rst_n     (rst_n),
        .clk_wr    (clk_wr),
        .clk_rd    (clk_rd),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .in_ready  (in_ready),
        .overflow  (overflow),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    function automatic logic [EW-1:0] mk(input int p0, input int p1, input int p2,
                                         input int p3, input logic s, input logic e);
        return {e, s, PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [EW-1:0] exp);
        logic [EW-1:0] got;
        got = 'x;
        if (rxq.size() > 0) got = rxq.pop_front();
        chk(tag, CW'(got), CW'(exp));
    endtask

    task automatic pix(input int v, input logic s, input logic e);
        @(negedge clk_wr);
        in_valid = 1'b1;
        in_pix   = PW'(v);
        in_sof   = s;
        in_eol   = e;
    endtask

    task automatic idle();
        @(negedge clk_wr);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic rd_cycles(input int n);
        repeat (n) @(negedge clk_rd);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rxq.size() < n && c < budget) begin
            @(negedge clk_rd);
            c++;
        end
    endtask

    // Consumer: pick out_ready for the coming edge, log the word if it will transfer
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk_rd);
            case (rd_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (rst_n && out_valid && out_ready) rxq.push_back({out_eol, out_sof, out_data});
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_pix = '0;
        repeat (4) @(negedge clk_wr);
        chk("rst_in_ready", CW'(in_ready), CW'(0));
        chk("rst_overflow", CW'(overflow), CW'(0));
        chk("rst_out_valid", CW'(out_valid), CW'(0));
        chk("rst_out_sof", CW'(out_sof), CW'(0));
        chk("rst_out_eol", CW'(out_eol), CW'(0));
        chk("rst_out_data", CW'(out_data), CW'(0));
        rst_n = 1'b1;
        #1 chk("ready_hold", CW'(in_ready), CW'(0));
        @(posedge clk_wr);
        #1 chk("ready_rise", CW'(in_ready), CW'(1));

        // Two full words, sof on the first
        rd_mode = 1;
        for (int i = 1; i <= 8; i++) pix(i, 1'(i == 1), 1'b0);
        idle();
        wait_rx(2, 200); rd_cycles(10);
        chk("A_cnt", CW'(rxq.size()), CW'(2));
        chk_word("A_w0", mk(1, 2, 3, 4, 1'b1, 1'b0));
        chk_word("A_w1", mk(5, 6, 7, 8, 1'b0, 1'b0));
        chk("A_overflow", CW'(overflow), CW'(0));

        // eol on the sixth pixel pads the partial word
        for (int i = 1; i <= 6; i++) pix(i, 1'(i == 1), 1'(i == 6));
        idle();
        wait_rx(2, 200); rd_cycles(10);
        chk("B_cnt", CW'(rxq.size()), CW'(2));
        chk_word("B_w0", mk(1, 2, 3, 4, 1'b1, 1'b0));
        chk_word("B_w1", mk(5, 6, 6, 6, 1'b0, 1'b1));

        // sof with three pixels pending discards them
        for (int i = 1; i <= 3; i++) pix(i, 1'(i == 1), 1'b0);
        for (int i = 9; i <= 12; i++) pix(i, 1'(i == 9), 1'b0);
        idle();
        wait_rx(1, 200); rd_cycles(20);
        chk("C_cnt", CW'(rxq.size()), CW'(1));
        chk_word("C_w0", mk(9, 10, 11, 12, 1'b1, 1'b0));

        // 80 pixels into a stalled consumer, ignoring in_ready
        rd_mode = 0;
        first_low = -1;
        for (int p = 0; p < 80; p++) begin
            @(negedge clk_wr);
            if (!in_ready && first_low < 0) first_low = p;
            in_valid = 1'b1; in_pix = PW'(100 + p); in_sof = 1'(p == 0); in_eol = 1'b0;
        end
        idle();
        rd_cycles(20);
        chk("D_first_low", CW'(first_low), CW'(58));
        chk("D_ready_low", CW'(in_ready), CW'(0));
        chk("D_overflow", CW'(overflow), CW'(1));
        chk("D_valid_stall", CW'(out_valid), CW'(1));
        chk("D_stall_data", CW'({out_eol, out_sof, out_data}), CW'(mk(100, 101, 102, 103, 1'b1, 1'b0)));
        rd_mode = 1;
        wait_rx(16, 400); rd_cycles(30);
        chk("D_cnt", CW'(rxq.size()), CW'(16));
        for (int w = 0; w < 16; w++)
            chk_word($sformatf("D_w%0d", w), mk(100 + 4*w, 101 + 4*w, 102 + 4*w, 103 + 4*w, 1'(w == 0), 1'b0));
        repeat (10) @(negedge clk_wr);
        chk("D_ready_back", CW'(in_ready), CW'(1));
        chk("D_overflow_sticky", CW'(overflow), CW'(1));
        pix(500, 1'b1, 1'b1);
        idle();
        chk("D_overflow_clr", CW'(overflow), CW'(0));
        wait_rx(1, 200); rd_cycles(10);
        chk("D_sof_eol_cnt", CW'(rxq.size()), CW'(1));
        chk_word("D_sof_eol", mk(500, 500, 500, 500, 1'b1, 1'b1));

        // Reset with five words queued
        rd_mode = 0;
        for (int i = 0; i < 20; i++) pix(300 + i, 1'(i == 0), 1'b0);
        idle();
        rd_cycles(30);
        chk("E_valid_before", CW'(out_valid), CW'(1));
        #2 rst_n = 1'b0;
        #1 chk("E_valid_rst", CW'(out_valid), CW'(0));
        chk("E_sof_rst", CW'(out_sof), CW'(0));
        chk("E_ready_rst", CW'(in_ready), CW'(0));
        repeat (3) @(negedge clk_wr);
        rxq.delete();
        @(negedge clk_wr);
        rst_n = 1'b1;
        rd_mode = 1;
        rd_cycles(20);
        chk("E_no_stale", CW'(out_valid), CW'(0));
        chk("E_cnt0", CW'(rxq.size()), CW'(0));
        for (int i = 0; i < 4; i++) pix(400 + i, 1'(i == 0), 1'b0);
        idle();
        wait_rx(1, 200); rd_cycles(20);
        chk("E_cnt", CW'(rxq.size()), CW'(1));
        chk_word("E_w0", mk(400, 401, 402, 403, 1'b1, 1'b0));

        // Stream of 100 words, 8-pixel lines, in_ready obeyed, random consumer stalls
        rd_mode = 2;
        begin
            int i = 0;
            int guard = 0;
            while (i < 400 && guard < 20000) begin
                @(negedge clk_wr);
                guard++;
                if (in_ready) begin
                    in_valid = 1'b1; in_pix = PW'(1000 + i);
                    in_sof = 1'(i == 0); in_eol = 1'(i % 8 == 7);
                    i++;
                end else begin
                    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
                end
            end
        end
        idle();
        wait_rx(100, 5000); rd_cycles(20);
        chk("F_cnt", CW'(rxq.size()), CW'(100));
        for (int k = 0; k < 100; k++)
            chk_word($sformatf("F_w%0d", k),
                     mk(1000 + 4*k, 1001 + 4*k, 1002 + 4*k, 1003 + 4*k, 1'(k == 0), 1'(k % 2 == 1)));
        chk("F_overflow", CW'(overflow), CW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
